// File: rtl/wired_dispatch_recv.sv
// Dispatch receiver: compacts 2-slot packages, allocates ROB ids against credit; WIRED_DISPATCH_SPLIT_EN splits 2-wide packages.
// Latency 1 cycle; beats hold while disp_ready is low and pkg_ready stays low until the final beat drains.
module wired_dispatch_recv #(
    parameter int   PKG_W     = 64,
    parameter int   ROB_DEPTH = 32,
    localparam int  ID_W      = $clog2(ROB_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  pkg_valid_i,
    output logic                  pkg_ready_o,
    input  logic [1:0]            pkg_mask_i,
    input  logic [2*PKG_W-1:0]    pkg_i,
    input  logic [1:0]            commit_cnt_i,
    output logic                  disp_valid_o,
    input  logic                  disp_ready_i,
    output logic [1:0]            disp_mask_o,
    output logic [2*PKG_W-1:0]    disp_o,
    output logic [2*ID_W-1:0]     disp_id_o,
    output logic [ID_W:0]         credit_o
);

`ifdef WIRED_DISPATCH_SPLIT_EN
    typedef enum logic [1:0] {EMPTY, FULL, SECOND} state_t;
`else
    typedef enum logic [0:0] {EMPTY, FULL} state_t;
`endif

    state_t              state, state_nxt;
    logic [ID_W-1:0]     tail;
    logic [ID_W:0]       credit;
    logic [ID_W:0]       n_acc;
    logic [1:0]          n;
    logic                drain, final_beat, accept, load;
    logic [1:0]          cmp_mask;
    logic [2*PKG_W-1:0]  cmp_dat;

`ifdef WIRED_DISPATCH_SPLIT_EN
    logic                pend;
    logic [PKG_W-1:0]    hold_dat;
    logic [ID_W-1:0]     hold_id;
    assign final_beat = !pend;
`else
    assign final_beat = 1'b1;
`endif

    assign n            = {1'b0, pkg_mask_i[0]} + {1'b0, pkg_mask_i[1]};
    assign disp_valid_o = (state != EMPTY);
    assign drain        = disp_valid_o && disp_ready_i;
    assign credit_o     = credit;
    // Credit test ignores the mask so ready never depends on pkg_mask_i.
    assign pkg_ready_o  = !rst && !flush_i && (credit >= (ID_W+1)'(2)) &&
                          ((state == EMPTY) || (drain && final_beat));
    assign accept       = pkg_valid_i && pkg_ready_o;
    assign load         = accept && (n != 2'd0);
    assign n_acc        = accept ? {{(ID_W-1){1'b0}}, n} : '0;

    always_comb begin
        cmp_mask = 2'b01;
        cmp_dat  = '0;
        case (pkg_mask_i)
            2'b11: begin
`ifdef WIRED_DISPATCH_SPLIT_EN
                cmp_dat[PKG_W-1:0] = pkg_i[PKG_W-1:0];
`else
                cmp_mask = 2'b11;
                cmp_dat  = pkg_i;
`endif
            end
            2'b10:   cmp_dat[PKG_W-1:0] = pkg_i[2*PKG_W-1:PKG_W];
            default: cmp_dat[PKG_W-1:0] = pkg_i[PKG_W-1:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else if (load) begin
            state_nxt = FULL;
        end else if (drain) begin
`ifdef WIRED_DISPATCH_SPLIT_EN
            state_nxt = pend ? SECOND : EMPTY;
`else
            state_nxt = EMPTY;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_mask_o <= '0;
            disp_o      <= '0;
            disp_id_o   <= '0;
            tail        <= '0;
            credit      <= (ID_W+1)'(ROB_DEPTH);
`ifdef WIRED_DISPATCH_SPLIT_EN
            pend        <= 1'b0;
            hold_dat    <= '0;
            hold_id     <= '0;
`endif
        end else if (flush_i) begin
            disp_mask_o <= '0;
            tail        <= '0;
            credit      <= (ID_W+1)'(ROB_DEPTH);
`ifdef WIRED_DISPATCH_SPLIT_EN
            pend        <= 1'b0;
`endif
        end else begin
            credit <= credit - n_acc + {{(ID_W-1){1'b0}}, commit_cnt_i};
            if (accept) begin
                tail <= tail + ID_W'(n);
            end
            if (load) begin
                disp_mask_o <= cmp_mask;
                disp_o      <= cmp_dat;
                disp_id_o   <= {tail + ID_W'(1), tail};
`ifdef WIRED_DISPATCH_SPLIT_EN
                // Both ids were allocated at acceptance; slot1 waits here for its own beat.
                pend        <= (pkg_mask_i == 2'b11);
                hold_dat    <= pkg_i[2*PKG_W-1:PKG_W];
                hold_id     <= tail + ID_W'(1);
`endif
            end else if (drain) begin
`ifdef WIRED_DISPATCH_SPLIT_EN
                if (pend) begin
                    disp_o    <= {{PKG_W{1'b0}}, hold_dat};
                    disp_id_o <= {hold_id + ID_W'(1), hold_id};
                    pend      <= 1'b0;
                end else begin
                    disp_mask_o <= '0;
                end
`else
                disp_mask_o <= '0;
`endif
            end
        end
    end

`ifndef SYNTHESIS
    commit_legal: assert property (@(posedge clk) disable iff (rst) commit_cnt_i != 2'd3);
`endif

endmodule

// File: tb/tb_wired_dispatch_recv.sv
// Bench for wired_dispatch_recv: directed vector table, multi-cycle corner sequences, randomized run against a queue model.
module tb_wired_dispatch_recv;
    localparam int W  = 64;
    localparam int RD = 32;
    localparam int IW = 5;
`ifdef WIRED_DISPATCH_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    localparam logic [W-1:0] A = 64'hAAAA_0000_0000_000A;
    localparam logic [W-1:0] B = 64'hBBBB_0000_0000_000B;
    localparam logic [W-1:0] C = 64'hCCCC_0000_0000_000C;
    localparam logic [W-1:0] D = 64'hDDDD_0000_0000_000D;
    localparam logic [W-1:0] E = 64'hEEEE_0000_0000_000E;
    localparam logic [W-1:0] F = 64'hFFFF_0000_0000_000F;
    localparam logic [W-1:0] G = 64'h1234_5678_9ABC_DEF0;
    localparam logic [W-1:0] H = 64'h0FED_CBA9_8765_4321;
    localparam logic [W-1:0] X = 64'hDEAD_BEEF_DEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            pkg_valid = 1'b0;
    logic            pkg_ready;
    logic [1:0]      pkg_mask = '0;
    logic [2*W-1:0]  pkg = '0;
    logic [1:0]      commit = '0;
    logic            disp_valid;
    logic            disp_ready = 1'b0;
    logic [1:0]      disp_mask;
    logic [2*W-1:0]  disp;
    logic [2*IW-1:0] disp_id;
    logic [IW:0]     credit;

    int checks = 0;
    int errors = 0;

    wired_dispatch_recv #(.PKG_W(W), .ROB_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .pkg_valid_i(pkg_valid), .pkg_ready_o(pkg_ready),
        .pkg_mask_i(pkg_mask), .pkg_i(pkg), .commit_cnt_i(commit),
        .disp_valid_o(disp_valid), .disp_ready_i(disp_ready),
        .disp_mask_o(disp_mask), .disp_o(disp), .disp_id_o(disp_id),
        .credit_o(credit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            assert (credit <= 6'(RD)) else $error("credit out of range: %0d", credit);
        end
    end

    typedef struct {
        logic [1:0]    m;
        logic [W-1:0]  s0, s1;
        logic [1:0]    c;
        logic          ev;
        logic [1:0]    em;
        logic [W-1:0]  e0, e1;
        logic [IW-1:0] i0, i1;
        logic [IW:0]   ecr;
    } vec_t;

    typedef struct {
        logic [1:0]    m;
        logic [W-1:0]  d0, d1;
        logic [IW-1:0] i0, i1;
    } beat_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] s0, input logic [W-1:0] s1,
                         input logic [1:0] c, input logic f, input logic r);
        pkg_valid  = v;
        pkg_mask   = m;
        pkg        = {s1, s0};
        commit     = c;
        flush      = f;
        disp_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, 2'd0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_valid", disp_valid, 0);
        chk("rst_ready", pkg_ready, 0);
        chk("rst_credit", credit, RD);
        chk("rst_mask", disp_mask, 0);
        chk("rst_disp", disp, 0);
        chk("rst_id", disp_id, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_ready", pkg_ready, 1);
    endtask

    vec_t  tbl[7];
    beat_t q[$];
    int    m_credit, m_tail, n, lim;
    logic  exp_rdy;
    beat_t b;

    initial begin
        tbl[0] = '{2'b11, A, B, 2'd0, 1'b1, 2'b11, A, B, 5'd0, 5'd1, 6'd30};
        tbl[1] = '{2'b10, X, C, 2'd0, 1'b1, 2'b01, C, '0, 5'd2, 5'd0, 6'd29};
        tbl[2] = '{2'b01, D, X, 2'd2, 1'b1, 2'b01, D, '0, 5'd3, 5'd0, 6'd30};
        tbl[3] = '{2'b00, X, X, 2'd1, 1'b0, 2'b00, '0, '0, 5'd0, 5'd0, 6'd31};
        tbl[4] = '{2'b11, E, F, 2'd0, 1'b1, 2'b11, E, F, 5'd4, 5'd5, 6'd29};
        tbl[5] = '{2'b01, G, X, 2'd1, 1'b1, 2'b01, G, '0, 5'd6, 5'd0, 6'd29};
        tbl[6] = '{2'b10, X, H, 2'd2, 1'b1, 2'b01, H, '0, 5'd7, 5'd0, 6'd30};

        do_reset();

`ifndef WIRED_DISPATCH_SPLIT_EN
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, tbl[i].m, tbl[i].s0, tbl[i].s1, tbl[i].c, 1'b0, 1'b1);
            #1 chk("tbl_ready", pkg_ready, 1);
            @(posedge clk);
            #1;
            chk("tbl_valid", disp_valid, tbl[i].ev);
            chk("tbl_credit", credit, tbl[i].ecr);
            if (tbl[i].ev) begin
                chk("tbl_mask", disp_mask, tbl[i].em);
                chk("tbl_slot0", disp[W-1:0], tbl[i].e0);
                chk("tbl_id0", disp_id[IW-1:0], tbl[i].i0);
            end
            if (tbl[i].em[1]) begin
                chk("tbl_slot1", disp[2*W-1:W], tbl[i].e1);
                chk("tbl_id1", disp_id[2*IW-1:IW], tbl[i].i1);
            end
        end

        // Fill the ROB with 16 two-wide packages, then free two entries.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, A, B, 2'd0, 1'b0, 1'b1);
            #1 chk("fill_ready_pre", pkg_ready, 1);
            @(posedge clk);
            #1;
            if (k == 15) begin
                chk("fill15_credit", credit, 2);
                chk("fill15_ready", pkg_ready, 1);
            end
            if (k == 16) begin
                chk("fill16_credit", credit, 0);
                chk("fill16_ready", pkg_ready, 0);
            end
        end
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, 2'd2, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("commit_credit", credit, 2);
        chk("commit_ready", pkg_ready, 1);
        @(negedge clk);
        drive(1'b1, 2'b11, G, H, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("wrap_ids", disp_id, {5'd1, 5'd0});
        chk("wrap_credit", credit, 0);

        // Flush beside an accept and a commit.
        @(negedge clk);
        drive(1'b1, 2'b11, E, F, 2'd2, 1'b1, 1'b0);
        #1 chk("flush_ready", pkg_ready, 0);
        @(posedge clk);
        #1;
        chk("flush_valid", disp_valid, 0);
        chk("flush_credit", credit, RD);
        @(negedge clk);
        drive(1'b1, 2'b11, A, B, 2'd0, 1'b0, 1'b1);
        #1 chk("post_flush_ready", pkg_ready, 1);
        @(posedge clk);
        #1;
        chk("post_flush_ids", disp_id, {5'd1, 5'd0});
        chk("post_flush_credit", credit, 30);

        // Backend stalls for 5 cycles.
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, C, D, 2'd0, 1'b0, 1'b0);
            #1;
            chk("stall_valid", disp_valid, 1);
            chk("stall_mask", disp_mask, 2'b11);
            chk("stall_disp", disp, {B, A});
            chk("stall_ids", disp_id, {5'd1, 5'd0});
            chk("stall_ready", pkg_ready, 0);
        end
        @(negedge clk);
        drive(1'b1, 2'b11, C, D, 2'd0, 1'b0, 1'b1);
        #1 chk("release_ready", pkg_ready, 1);
        @(posedge clk);
        #1;
        chk("release_disp", disp, {D, C});
        chk("release_ids", disp_id, {5'd3, 5'd2});
        chk("release_credit", credit, 28);
`else
        @(negedge clk);
        drive(1'b1, 2'b11, A, B, 2'd0, 1'b0, 1'b1);
        #1 chk("split_ready0", pkg_ready, 1);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, 2'd0, 1'b0, 1'b1);
        #1;
        chk("split_a_mask", disp_mask, 2'b01);
        chk("split_a_dat", disp[W-1:0], A);
        chk("split_a_id", disp_id[IW-1:0], 0);
        chk("split_a_ready", pkg_ready, 0);
        chk("split_credit", credit, 30);
        @(negedge clk);
        #1;
        chk("split_b_mask", disp_mask, 2'b01);
        chk("split_b_dat", disp[W-1:0], B);
        chk("split_b_id", disp_id[IW-1:0], 1);
        chk("split_b_ready", pkg_ready, 1);
        @(negedge clk);
        #1 chk("split_drained", disp_valid, 0);
`endif

        // Reset arriving while a beat is held.
        do_reset();
        @(negedge clk);
        drive(1'b1, 2'b01, C, X, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("mid_valid_pre", disp_valid, 1);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_valid", disp_valid, 0);
        chk("mid_disp", disp, 0);
        chk("mid_credit", credit, RD);
        chk("mid_ready", pkg_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_release_ready", pkg_ready, 1);

        // Randomized run against the queue model.
        do_reset();
        q.delete();
        m_credit = RD;
        m_tail   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                chk("rnd_valid", disp_valid, 0);
            end else begin
                chk("rnd_valid", disp_valid, 1);
                chk("rnd_mask", disp_mask, q[0].m);
                chk("rnd_slot0", disp[W-1:0], q[0].d0);
                chk("rnd_id0", disp_id[IW-1:0], q[0].i0);
                if (q[0].m[1]) begin
                    chk("rnd_slot1", disp[2*W-1:W], q[0].d1);
                    chk("rnd_id1", disp_id[2*IW-1:IW], q[0].i1);
                end
            end
            chk("rnd_credit", credit, m_credit);
            lim = RD - m_credit;
            if (lim > 2) lim = 2;
            drive($urandom_range(0, 9) < 6, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  2'($urandom_range(0, lim)), $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7);
            exp_rdy = !flush && (m_credit >= 2) && ((q.size() == 0) || (q.size() == 1 && disp_ready));
            #1 chk("rnd_ready", pkg_ready, exp_rdy);
            @(posedge clk);
            if (flush) begin
                q.delete();
                m_credit = RD;
                m_tail   = 0;
            end else begin
                if (q.size() > 0 && disp_ready) void'(q.pop_front());
                if (exp_rdy && pkg_valid) begin
                    n = int'(pkg_mask[0]) + int'(pkg_mask[1]);
                    b.d1 = '0;
                    b.i1 = '0;
                    b.m  = 2'b01;
                    b.i0 = IW'(m_tail);
                    if (pkg_mask == 2'b11 && !SPLIT) begin
                        b.m  = 2'b11;
                        b.d0 = pkg[W-1:0];
                        b.d1 = pkg[2*W-1:W];
                        b.i1 = IW'((m_tail + 1) % RD);
                        q.push_back(b);
                    end else if (pkg_mask == 2'b11) begin
                        b.d0 = pkg[W-1:0];
                        q.push_back(b);
                        b.d0 = pkg[2*W-1:W];
                        b.i0 = IW'((m_tail + 1) % RD);
                        q.push_back(b);
                    end else if (pkg_mask == 2'b10) begin
                        b.d0 = pkg[2*W-1:W];
                        q.push_back(b);
                    end else if (pkg_mask == 2'b01) begin
                        b.d0 = pkg[W-1:0];
                        q.push_back(b);
                    end
                    m_credit = m_credit - n;
                    m_tail   = (m_tail + n) % RD;
                end
                m_credit = m_credit + int'(commit);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
